// File: rtl/bell_pkg.sv
// rtl/bell_pkg.sv - note half-period table, state encoding and classifier for the bell tone decoder
package bell_pkg;

  localparam int BELL_CODE_W = 3;
  localparam int DEF_HALF_W  = 16;
  localparam int DEF_TOL     = 64;
  localparam int DEF_CONFIRM = 3;
  localparam int DEF_TIMEOUT = 50000;

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } dec_state_t;

  function automatic int unsigned half_ref(input int k);
    case (k)
      1:       half_ref = 23890;
      2:       half_ref = 21283;
      3:       half_ref = 18962;
      4:       half_ref = 17898;
      5:       half_ref = 15945;
      6:       half_ref = 14206;
      7:       half_ref = 12656;
      default: half_ref = 0;
    endcase
  endfunction

  // Windows never overlap because TOL is below half the smallest table gap.
  function automatic logic [BELL_CODE_W-1:0] classify(input int unsigned h, input int unsigned tol);
    int unsigned ref_h;
    int unsigned diff;
    classify = '0;
    for (int k = 1; k <= 7; k++) begin
      ref_h = half_ref(k);
      diff  = (h >= ref_h) ? (h - ref_h) : (ref_h - h);
      if (diff <= tol) classify = BELL_CODE_W'(k);
    end
  endfunction

endpackage

// File: rtl/bell_edge_sync.sv
// rtl/bell_edge_sync.sv - two-flop synchroniser with either-polarity edge strobe
module bell_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tone_in,
  output logic edge_strobe
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tone_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_strobe = s2 ^ s3;

endmodule

// File: rtl/bell_tone_decoder.sv
// rtl/bell_tone_decoder.sv - half-period measurement and note classification of a square-wave tone
// Optional BELL_DEC_PERIOD_OUT_EN exposes the last measured half-period on half_period.
module bell_tone_decoder
  import bell_pkg::*;
#(
  parameter int          HALF_W  = DEF_HALF_W,
  parameter int unsigned TOL     = DEF_TOL,
  parameter int          CONFIRM = DEF_CONFIRM,
  parameter int          TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tone_in,
  output logic [BELL_CODE_W-1:0] bell_code,
  output logic                   code_valid
`ifdef BELL_DEC_PERIOD_OUT_EN
  ,
  output logic [HALF_W-1:0]      half_period
`endif
);

  logic                   edge_strobe;
  logic [HALF_W-1:0]      cnt;
  logic [HALF_W-1:0]      h_meas;
  logic                   cnt_sat;
  logic [BELL_CODE_W-1:0] match;
  logic [2:0]             streak, streak_nx;
  logic [BELL_CODE_W-1:0] cand, cand_nx;
  logic                   reach, timeout, clr_streak;
  dec_state_t             state, state_nx;
  logic [BELL_CODE_W-1:0] code_nx;
  logic                   valid_nx;

  bell_edge_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .tone_in     (tone_in),
    .edge_strobe (edge_strobe)
  );

  assign cnt_sat = (cnt == HALF_W'(TIMEOUT));
  assign h_meas  = cnt + HALF_W'(1);
  // A saturated counter means the interval is longer than any note: never a match.
  assign match   = cnt_sat ? '0 : classify(32'(h_meas), TOL);

  always_comb begin
    streak_nx = streak;
    cand_nx   = cand;
    if (edge_strobe) begin
      if (match == '0) begin
        streak_nx = '0;
        cand_nx   = '0;
      end else if (match == cand) begin
        streak_nx = (streak == 3'(CONFIRM)) ? streak : streak + 3'd1;
      end else begin
        cand_nx   = match;
        streak_nx = 3'd1;
      end
    end
  end

  assign reach   = edge_strobe && (streak_nx == 3'(CONFIRM));
  // Fires on the cycle the counter saturates; an edge in that cycle takes priority.
  assign timeout = !edge_strobe && (cnt >= HALF_W'(TIMEOUT - 1));

  always_comb begin
    state_nx   = state;
    code_nx    = bell_code;
    valid_nx   = 1'b0;
    clr_streak = 1'b0;
    case (state)
      SILENT: begin
        if (edge_strobe) state_nx = ACQUIRE;
      end
      ACQUIRE: begin
        if (reach) begin
          code_nx  = cand_nx;
          valid_nx = 1'b1;
          state_nx = LOCKED;
        end else if (timeout) begin
          state_nx   = SILENT;
          clr_streak = 1'b1;
        end
      end
      LOCKED: begin
        if (reach && (cand_nx != bell_code)) begin
          code_nx  = cand_nx;
          valid_nx = 1'b1;
        end else if (timeout) begin
          code_nx    = '0;
          valid_nx   = 1'b1;
          state_nx   = SILENT;
          clr_streak = 1'b1;
        end
      end
      default: state_nx = SILENT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= HALF_W'(TIMEOUT);
      streak     <= '0;
      cand       <= '0;
      state      <= SILENT;
      bell_code  <= '0;
      code_valid <= 1'b0;
    end else begin
      if (edge_strobe)  cnt <= '0;
      else if (!cnt_sat) cnt <= cnt + HALF_W'(1);
      streak     <= clr_streak ? 3'd0 : streak_nx;
      cand       <= cand_nx;
      state      <= state_nx;
      bell_code  <= code_nx;
      code_valid <= valid_nx;
    end
  end

`ifdef BELL_DEC_PERIOD_OUT_EN
  always_ff @(posedge clk) begin
    if (!rst)             half_period <= '0;
    else if (edge_strobe) half_period <= h_meas;
  end
`endif

endmodule

// File: tb/tb_bell_tone_decoder.sv
// tb/tb_bell_tone_decoder.sv - directed vector bench for bell_tone_decoder
module tb_bell_tone_decoder;

  localparam int TO = 26000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tone_in = 1'b0;
  logic [2:0] bell_code;
  logic       code_valid;
`ifdef BELL_DEC_PERIOD_OUT_EN
  logic [15:0] half_period;
`endif

  bell_tone_decoder #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .tone_in    (tone_in),
    .bell_code  (bell_code),
    .code_valid (code_valid)
`ifdef BELL_DEC_PERIOD_OUT_EN
    ,
    .half_period(half_period)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         pulse_cnt = 0;
  int         last_pulse_cyc = 0;
  logic [2:0] last_pulse_code = 3'd0;
  bit         arm_zero = 1'b0;
  bit         zero_seen = 1'b0;

  always @(negedge clk) begin
    if (code_valid) begin
      pulse_cnt       = pulse_cnt + 1;
      last_pulse_cyc  = cyc;
      last_pulse_code = bell_code;
    end
    if (arm_zero && bell_code == 3'd0) zero_seen = 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  int slack = 0;
  int tog_cyc[8];
  int last_tog = 0;

  // Each toggle follows h clocks after the previous one, so every measured half equals h.
  task automatic run_block(input int h, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (h - ((i == 0) ? slack : 0)) @(posedge clk);
      #1 tone_in = ~tone_in;
      tog_cyc[i] = cyc;
    end
    repeat (6) @(posedge clk);
    #1;
    slack    = 6;
    last_tog = tog_cyc[n-1];
  endtask

  typedef struct {
    int    h;
    int    n;
    int    exp_code;
    int    exp_pulses;
    int    lock_idx;
    bit    no_zero;
    string name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int p0;
    int waited;

    vecs[0] = '{15945, 5, 5, 1, 4, 1'b0, "lock5"};
    vecs[1] = '{23890, 3, 1, 1, 3, 1'b1, "switch5to1"};
    vecs[2] = '{16009, 4, 5, 1, 3, 1'b0, "tol_plus64"};
    vecs[3] = '{16010, 2, 5, 0, 0, 1'b0, "tol_plus65"};
    vecs[4] = '{20000, 2, 5, 0, 0, 1'b0, "h20000"};
    vecs[5] = '{15881, 3, 5, 0, 0, 1'b0, "tol_minus64_same"};
    vecs[6] = '{15880, 2, 5, 0, 0, 1'b0, "tol_minus65"};
    vecs[7] = '{18962, 3, 3, 1, 3, 1'b0, "switch5to3"};

    // Reset held while the pin toggles
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("rst_code", bell_code, 0);
      check("rst_valid", code_valid, 0);
      tone_in = ~tone_in;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_code", bell_code, 0);
    check("post_rst_valid", code_valid, 0);
    slack = 1;

    for (int v = 0; v < 8; v++) begin
      p0        = pulse_cnt;
      zero_seen = 1'b0;
      arm_zero  = vecs[v].no_zero;
      run_block(vecs[v].h, vecs[v].n);
      arm_zero  = 1'b0;
      check({vecs[v].name, "_code"}, bell_code, vecs[v].exp_code);
      check({vecs[v].name, "_pulses"}, pulse_cnt - p0, vecs[v].exp_pulses);
      if (vecs[v].lock_idx > 0) begin
        check({vecs[v].name, "_pulse_code"}, last_pulse_code, vecs[v].exp_code);
        check_range({vecs[v].name, "_latency"}, last_pulse_cyc - tog_cyc[vecs[v].lock_idx-1], 3, 4);
      end
      if (vecs[v].no_zero) check({vecs[v].name, "_never0"}, zero_seen, 0);
    end

    // One-clock reset while locked on note 3, then full reacquisition
    p0  = pulse_cnt;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_code", bell_code, 0);
    check("midrst_valid", code_valid, 0);
    rst   = 1'b1;
    slack = 0;
    run_block(18962, 3);
    check("relock3_code", bell_code, 0);
    check("relock3_pulses", pulse_cnt - p0, 0);
    run_block(18962, 1);
    check("relock4_code", bell_code, 3);
    check("relock4_pulses", pulse_cnt - p0, 1);
    check_range("relock4_latency", last_pulse_cyc - tog_cyc[0], 3, 4);

    // Tone stops while locked
    p0     = pulse_cnt;
    waited = 0;
    while (pulse_cnt == p0 && waited < TO + 50) begin
      @(posedge clk);
      waited++;
    end
    repeat (4) @(posedge clk);
    #1;
    check("timeout_pulses", pulse_cnt - p0, 1);
    check("timeout_code", bell_code, 0);
    check_range("timeout_latency", last_pulse_cyc - last_tog, TO + 2, TO + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
